// File: rtl/pmod_pwm_pkg.sv
// Shared state type and helpers for the pmod_pwm_bank PWM output bank.
package pmod_pwm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } pwm_state_e;

    // Channel-select width; a single-channel bank still carries a 1-bit select.
    function automatic int ch_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    // Pin level that turns a channel off: high for sink-driven (active-low) pins.
    function automatic logic off_level(input int active_low);
        return (active_low != 0);
    endfunction

endpackage

// File: rtl/pmod_pwm_bank_if.sv
// Duty-write port of pmod_pwm_bank (valid/ready plus error pulse).
// PMOD_PWM_BREATHE_EN adds the per-write wr_breathe flag.
interface pmod_pwm_bank_if
    import pmod_pwm_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int CNT_W  = 8
);
    localparam int CH_W = ch_w(NUM_CH);

    logic             wr_valid;
    logic             wr_ready;
    logic [CH_W-1:0]  wr_ch;
    logic [CNT_W-1:0] wr_duty;
    logic             wr_err;
`ifdef PMOD_PWM_BREATHE_EN
    logic             wr_breathe;

    modport master (output wr_valid, wr_ch, wr_duty, wr_breathe, input wr_ready, wr_err);
    modport slave  (input wr_valid, wr_ch, wr_duty, wr_breathe, output wr_ready, wr_err);
`else
    modport master (output wr_valid, wr_ch, wr_duty, input wr_ready, wr_err);
    modport slave  (input wr_valid, wr_ch, wr_duty, output wr_ready, wr_err);
`endif

endinterface

// File: rtl/pmod_pwm_timebase.sv
// Prescaler and period counter for pmod_pwm_bank: tick, wrap (load point) and
// the registered period_start pulse.
module pmod_pwm_timebase #(
    parameter int CNT_W    = 8,
    parameter int PRESCALE = 1
) (
    input  logic             pll_clk,
    input  logic             rst_n,
    input  logic             i_run,
    input  logic             i_start,
    input  logic             i_stop,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_wrap,
    output logic             o_period_start
);
    localparam int               PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((2 ** CNT_W) - 2);

    logic [PS_W-1:0]  r_presc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_period_start;
    logic             w_tick;

    assign w_tick         = i_run && (r_presc == PS_LAST);
    assign o_wrap         = w_tick && (r_cnt == CNT_LAST);
    assign o_cnt          = r_cnt;
    assign o_period_start = r_period_start;

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge pll_clk) begin
        if (!rst_n) begin
            r_presc        <= '0;
            r_cnt          <= '0;
            r_period_start <= 1'b0;
        end else begin
            // A wrap that sends the bank back to IDLE does not open a new period.
            r_period_start <= i_start || (o_wrap && !i_stop);
            if (!i_run) begin
                r_presc <= '0;
                r_cnt   <= '0;
            end else if (w_tick) begin
                r_presc <= '0;
                r_cnt   <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
            end else begin
                r_presc <= r_presc + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pmod_pwm_bank.sv
// NUM_CH-channel PWM pin driver with double-buffered duties and a run/drain/idle
// controller. Define PMOD_PWM_BREATHE_EN for per-channel breathing ramps.
module pmod_pwm_bank
    import pmod_pwm_pkg::*;
#(
    parameter int NUM_CH     = 3,
    parameter int CNT_W      = 8,
    parameter int PRESCALE   = 1,
    parameter int ACTIVE_LOW = 1
) (
    input  logic              pll_clk,
    input  logic              rst_n,
    input  logic              enable,
    pmod_pwm_bank_if.slave    wr_if,
    output logic              period_start,
    output logic              busy,
    output logic [NUM_CH-1:0] pwm_out
);
    localparam logic [NUM_CH-1:0] OFF_VEC = {NUM_CH{off_level(ACTIVE_LOW)}};

    pwm_state_e        r_state;
    logic              r_busy;
    logic              r_ready;
    logic              r_err;
    logic [NUM_CH-1:0] r_pwm;
    logic [CNT_W-1:0]  r_shadow [NUM_CH];
    logic [CNT_W-1:0]  r_active [NUM_CH];

    logic [CNT_W-1:0]  w_cnt;
    logic              w_wrap;
    logic              w_run;
    logic              w_start;
    logic              w_stop;
    logic              w_load;
    logic              w_accept;
    logic              w_ch_ok;
    logic              w_period_start;
    logic [NUM_CH-1:0] w_on;

    assign w_run    = (r_state != ST_IDLE);
    assign w_start  = (r_state == ST_IDLE) && enable;
    assign w_stop   = (r_state == ST_DRAIN) && !enable && w_wrap;
    assign w_load   = w_start || (w_wrap && !w_stop);
    assign w_accept = wr_if.wr_valid && r_ready;
    assign w_ch_ok  = int'(wr_if.wr_ch) < NUM_CH;

    pmod_pwm_timebase #(
        .CNT_W    (CNT_W),
        .PRESCALE (PRESCALE)
    ) u_timebase (
        .pll_clk        (pll_clk),
        .rst_n          (rst_n),
        .i_run          (w_run),
        .i_start        (w_start),
        .i_stop         (w_stop),
        .o_cnt          (w_cnt),
        .o_wrap         (w_wrap),
        .o_period_start (w_period_start)
    );

    always_ff @(posedge pll_clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (enable) begin
                    r_state <= ST_RUN;
                    r_busy  <= 1'b1;
                end
                ST_RUN: if (!enable) r_state <= ST_DRAIN;
                ST_DRAIN: if (enable) begin
                    r_state <= ST_RUN;
                end else if (w_wrap) begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef PMOD_PWM_BREATHE_EN
    logic [NUM_CH-1:0] r_breathe;
    logic [NUM_CH-1:0] r_falling;
    logic [CNT_W-1:0]  w_step [NUM_CH];
    logic [NUM_CH-1:0] w_step_fall;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_step[i]      = r_active[i];
            w_step_fall[i] = r_falling[i];
            if (r_shadow[i] == '0) begin
                w_step[i]      = '0;
                w_step_fall[i] = 1'b0;
            end else begin
                if (!r_falling[i] && (r_active[i] < r_shadow[i])) begin
                    w_step[i] = r_active[i] + 1'b1;
                end else if (r_active[i] != '0) begin
                    w_step[i] = r_active[i] - 1'b1;
                end
                if (w_step[i] == r_shadow[i]) begin
                    w_step_fall[i] = 1'b1;
                end else if (w_step[i] == '0) begin
                    w_step_fall[i] = 1'b0;
                end
            end
        end
    end
`endif

    // NOTE: shadow duties are reset explicitly; a reset must leave every channel off.
    always_ff @(posedge pll_clk) begin
        if (!rst_n) begin
            r_ready  <= 1'b0;
            r_err    <= 1'b0;
            r_shadow <= '{default: '0};
`ifdef PMOD_PWM_BREATHE_EN
            r_breathe <= '0;
`endif
        end else begin
            r_ready <= 1'b1;
            r_err   <= w_accept && !w_ch_ok;
            if (w_accept && w_ch_ok) begin
                r_shadow[wr_if.wr_ch] <= wr_if.wr_duty;
`ifdef PMOD_PWM_BREATHE_EN
                r_breathe[wr_if.wr_ch] <= wr_if.wr_breathe;
`endif
            end
        end
    end

    always_ff @(posedge pll_clk) begin
        if (!rst_n) begin
            r_active <= '{default: '0};
`ifdef PMOD_PWM_BREATHE_EN
            r_falling <= '0;
`endif
        end else if (w_load) begin
            for (int i = 0; i < NUM_CH; i++) begin
`ifdef PMOD_PWM_BREATHE_EN
                if (r_breathe[i]) begin
                    r_active[i]  <= w_step[i];
                    r_falling[i] <= w_step_fall[i];
                end else begin
                    r_active[i] <= r_shadow[i];
                end
`else
                r_active[i] <= r_shadow[i];
`endif
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_on[i] = (w_cnt < r_active[i]);
        end
    end

    always_ff @(posedge pll_clk) begin
        if (!rst_n || (r_state == ST_IDLE)) begin
            r_pwm <= OFF_VEC;
        end else begin
            r_pwm <= w_on ^ OFF_VEC;
        end
    end

    assign wr_if.wr_ready = r_ready;
    assign wr_if.wr_err   = r_err;
    assign period_start   = w_period_start;
    assign busy           = r_busy;
    assign pwm_out        = r_pwm;

endmodule
